// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// Holds the fetch FSM state encoding, XLEN, PC increment and NOP encoding.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_INC   = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_next_mux.sv
// Next-PC selection: sequential pc+4 or word-aligned ALU target.
// Ports: pc, pc_sel, alu_data in; pc_next, pc_four out.
module pc_next_mux
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] alu_data,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc_four
);

    // Wraps modulo 2^32 at the top of the address space.
    assign pc_four = pc + PC_INC;

    // Target low bits are cleared so the PC is always word aligned.
    assign pc_next = pc_sel ? (alu_data & ~32'd3) : pc_four;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid fetch, holds PC.
// Ports: clk, rst (async high), pc_sel, alu_data, fe_stall, imem_* handshake,
// instr/instr_vld/pc/pc_four to decode. Optional: FETCH_ALIGN_CHECK_EN adds
// misalign_err, a sticky flag for jump targets with nonzero bits [1:0].
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = cpu_pkg::NOP_INSN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_sel,
    input  logic [31:0] alu_data,
    input  logic        fe_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_vld,
    output logic [31:0] pc,
    output logic [31:0] pc_four
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    fetch_state_e state;
    logic [31:0]  pc_next;
    logic         consume;

    pc_next_mux u_pc_next_mux (
        .pc       (pc),
        .pc_sel   (pc_sel),
        .alu_data (alu_data),
        .pc_next  (pc_next),
        .pc_four  (pc_four)
    );

    assign imem_req  = (state == REQ);
    assign imem_addr = pc & ~32'd3;
    assign consume   = (state == VALID) && !fe_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            instr     <= NOP_INSN;
            instr_vld <= 1'b0;
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_gnt) state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr     <= imem_rdata;
                        instr_vld <= 1'b1;
                        state     <= VALID;
                    end
                end
                VALID: begin
                    if (!fe_stall) begin
                        pc        <= pc_next;
                        instr     <= NOP_INSN;
                        instr_vld <= 1'b0;
                        state     <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (consume && pc_sel && (alu_data[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed fetches with a driven memory,
// expected addresses/instructions queued and checked by a negedge monitor.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_sel;
    logic [31:0] alu_data;
    logic        fe_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_vld;
    logic [31:0] pc;
    logic [31:0] pc_four;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    int checks = 0;
    int errors = 0;

    logic [31:0] addr_q[$];
    logic [63:0] ins_q[$];

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_sel      (pc_sel),
        .alu_data    (alu_data),
        .fe_stall    (fe_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_vld   (instr_vld),
        .pc          (pc),
        .pc_four     (pc_four)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations when the DUT presents a grant or a
    // consumed instruction; also checks stability under stall/no-gnt.
    logic        pend;
    logic [31:0] pend_addr;
    logic        held;
    logic [31:0] held_instr;
    logic [31:0] held_pc;

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            held = 1'b0;
        end else begin
            if (imem_req && pend)
                chk32("addr_stable", imem_addr, pend_addr);
            if (imem_req && imem_gnt) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL gnt_unexpected: got addr %h expected none",
                             imem_addr);
                end else begin
                    chk32("imem_addr", imem_addr, addr_q.pop_front());
                end
            end
            pend      = imem_req && !imem_gnt;
            pend_addr = imem_addr;

            if (!instr_vld)
                chk32("instr_nop", instr, NOP);

            if (instr_vld && fe_stall) begin
                chk32("stall_req", {31'd0, imem_req}, 32'd0);
                if (held) begin
                    chk32("stall_instr", instr, held_instr);
                    chk32("stall_pc", pc, held_pc);
                end
                held       = 1'b1;
                held_instr = instr;
                held_pc    = pc;
            end else begin
                held = 1'b0;
            end

            if (instr_vld && !fe_stall) begin
                if (ins_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL consume_unexpected: got instr %h expected none",
                             instr);
                end else begin
                    logic [63:0] e;
                    e = ins_q.pop_front();
                    chk32("instr", instr, e[63:32]);
                    chk32("pc", pc, e[31:0]);
                    chk32("pc_four", pc_four, e[31:0] + 32'd4);
                end
            end
        end
    end

    // One fetch: a = expected address, d = memory data, gd/rd = gnt/rvalid
    // wait states, st = stall cycles, sel/tgt = redirect at consumption,
    // ew = expected cycles spent waiting for imem_req.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                         input int gd, input int rd, input int st,
                         input logic sel, input logic [31:0] tgt,
                         input int ew);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no imem_req expected req at %h", a);
            return;
        end
        chk32("req_wait", n, ew);
        addr_q.push_back(a);
        ins_q.push_back({d, a});
        repeat (gd) step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk32("wait_req_low", {31'd0, imem_req}, 32'd0);
        repeat (rd) step();
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        chk32("vld_after_rvalid", {31'd0, instr_vld}, 32'd1);
        repeat (st) step();
        pc_sel   = sel;
        alu_data = tgt;
        fe_stall = 1'b0;
        step();
        fe_stall = 1'b1;
        pc_sel   = 1'b1;
        alu_data = 32'h0BAD_0001;
        chk32("vld_clear", {31'd0, instr_vld}, 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk32("rst_instr", instr, NOP);
        chk32("rst_vld", {31'd0, instr_vld}, 32'd0);
        chk32("rst_req", {31'd0, imem_req}, 32'd0);
        chk32("rst_addr", imem_addr, 32'd0);
        chk32("rst_pc", pc, 32'd0);
        chk32("rst_pc_four", pc_four, 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
        chk32("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif
    endtask

    initial begin
        rst         = 1'b1;
        pc_sel      = 1'b0;
        alu_data    = 32'd0;
        fe_stall    = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        repeat (3) step();
        chk_reset_vals();
        rst = 1'b0;

        fetch(32'h0000_0000, 32'h0050_0093, 0, 0, 0, 1'b0, 32'd0, 1);
        fetch(32'h0000_0004, 32'h0010_0113, 0, 0, 0, 1'b0, 32'd0, 0);
        fetch(32'h0000_0008, 32'h0020_0193, 0, 0, 5, 1'b0, 32'd0, 0);
        fetch(32'h0000_000C, 32'h0030_0213, 0, 0, 0, 1'b1, 32'h100, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk32("misalign_clean", {31'd0, misalign_err}, 32'd0);
`endif
        fetch(32'h0000_0100, 32'h0040_0293, 0, 0, 0, 1'b1, 32'h102, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk32("misalign_set", {31'd0, misalign_err}, 32'd1);
`endif
        fetch(32'h0000_0100, 32'h0060_0313, 4, 3, 0, 1'b1, 32'hFFFF_FFFC, 0);
        fetch(32'hFFFF_FFFC, 32'h0070_0393, 0, 0, 0, 1'b0, 32'd0, 0);
        fetch(32'h0000_0000, 32'h0080_0413, 0, 0, 0, 1'b0, 32'd0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk32("misalign_sticky", {31'd0, misalign_err}, 32'd1);
`endif

        // Reset with a granted but unreturned request in flight.
        chk32("abort_req", {31'd0, imem_req}, 32'd1);
        addr_q.push_back(32'h0000_0004);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk_reset_vals();
        step();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBADB_AD00;
        step();
        chk32("stale_req", {31'd0, imem_req}, 32'd1);
        chk32("stale_addr", imem_addr, 32'd0);
        step();
        imem_rvalid = 1'b0;
        chk32("stale_vld", {31'd0, instr_vld}, 32'd0);
        fetch(32'h0000_0000, 32'h0090_0493, 0, 0, 0, 1'b0, 32'd0, 0);

        step();
        chk32("addr_q_empty", addr_q.size(), 32'd0);
        chk32("ins_q_empty", ins_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the decode/control unit.
- Holds the PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched word as `instr` with a valid flag, and updates the PC from the control unit's `pc_sel` and the ALU branch/jump target.
- Single outstanding request; downstream back-pressure via `fe_stall`.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0013, value driven on `instr` when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_sel  input  1  from control unit; 1 = take `alu_data` as next PC, 0 = PC+4.
- alu_data  input  32  branch/jump target from the ALU.
- fe_stall  input  1  downstream cannot accept the current instruction this cycle.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word-aligned fetch address.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- instr  output  32  instruction to the decode/control unit.
- instr_vld  output  1  `instr` holds a fetched instruction.
- pc  output  32  address of `instr`.
- pc_four  output  32  pc + 4, for the writeback link value.

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=RESET_PC, instr=NOP_INSN, instr_vld=0, imem_req=0, imem_addr=RESET_PC.
- State IDLE: entered only from reset; moves to REQ on the first clock edge after rst deasserts.
- State REQ:
  - imem_req=1, imem_addr={pc[31:2],2'b00}.
  - imem_gnt=1 -> WAIT; otherwise hold REQ with addr stable. imem_req is never dropped before gnt.
- State WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> register instr=imem_rdata, set instr_vld=1, go to VALID. The data appears on `instr` the cycle after rvalid.
- State VALID:
  - instr_vld=1 and `instr` stays stable while fe_stall=1.
  - On fe_stall=0, the instruction is consumed at the edge:
    - pc <= pc_sel ? {alu_data[31:2],2'b00} : pc+4
    - instr <= NOP_INSN, instr_vld <= 0, next state REQ.
- pc_sel and alu_data are sampled only in VALID with fe_stall=0; they are ignored in all other states.
- imem_rvalid outside WAIT, and imem_gnt outside REQ, are ignored.
- pc_four = pc + 32'd4, combinational, modulo 2^32. At pc=32'hFFFF_FFFC the PC wraps to 0.
- Latency: minimum 3 cycles per instruction: REQ (gnt same cycle) -> WAIT (rvalid) -> VALID (consumed).
- Memory wait states extend REQ/WAIT indefinitely; there is no timeout.
- Reset mid-operation (any state, including a granted but unreturned request): immediate return to reset values. A late rvalid after reset falls into IDLE/REQ and is discarded.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - Adds output `misalign_err` (1 bit), reset 0.
  - Sets to 1 at a consuming edge in which pc_sel=1 and alu_data[1:0]!=2'b00, and stays set until reset.
  - The PC still loads the target with bits [1:0] forced to zero.
- When undefined: the port is absent and target bits [1:0] are silently cleared.

Decomposition:
- Shared package (cpu_pkg): fetch_state_e enum (IDLE, REQ, WAIT, VALID), NOP_INSN constant, XLEN=32, PC_INC=4.
- pc_next computation as sub-module `pc_next_mux`: inputs pc, pc_sel, alu_data; outputs next PC and pc_four.
- FSM and registers stay in fetch_stage.

Test Plan:
- Reset release, memory answers gnt immediately and rvalid next cycle with 32'h0050_0093 -> imem_addr=0 in REQ; instr=32'h0050_0093, instr_vld=1, pc=0, pc_four=4 two cycles after REQ.
- Sequential run of 3 instructions with fe_stall=0 and pc_sel=0 -> imem_addr sequence 0, 4, 8; one instruction every 3 cycles.
- fe_stall=1 for 5 cycles in VALID -> instr/pc unchanged, imem_req=0 throughout; on release PC advances by 4.
- pc_sel=1 with alu_data=32'h0000_0100 at consumption -> next imem_addr=32'h100. With alu_data=32'h102 -> addr 32'h100, and misalign_err=1 when FETCH_ALIGN_CHECK_EN is defined.
- gnt delayed 4 cycles and rvalid delayed 3 cycles -> imem_req held high with stable addr until gnt; instr_vld rises the cycle after rvalid.
- rst asserted in WAIT, and stale rvalid returned 1 cycle after rst deasserts -> outputs at reset values, rvalid ignored, first fetch from RESET_PC.
